// File: rtl/vfpu_f2i_pkg.sv
// Shared FP32 constants, the result flag struct and the operand class enum.
// Imported by the float-to-int converter and its handshake interface.
package hwpe_ctrl_vfpu_package;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  typedef struct packed {
    logic invalid;
    logic inexact;
  } vfpu_f2i_flags_t;

  typedef enum logic [2:0] {ZERO, SUBNORM, NORMAL, INF, NAN} fp_class_t;
endpackage

// File: rtl/vfpu_f2i_if.sv
// Operand and result valid/ready channels of the float-to-int converter.
// master drives operands and consumes results; slave is the converter.
interface vfpu_f2i_if #(parameter int INT_WIDTH = 32);
  import hwpe_ctrl_vfpu_package::*;

  logic [31:0]          in_data_i;
  logic                 in_signed_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [INT_WIDTH-1:0] out_data_o;
  vfpu_f2i_flags_t      out_flags_o;
  logic                 out_valid_o;
  logic                 out_ready_i;

  modport master (
    output in_data_i, in_signed_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_flags_o, out_valid_o
  );

  modport slave (
    input  in_data_i, in_signed_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_flags_o, out_valid_o
  );
endinterface

// File: rtl/vfpu_rshift.sv
// Combinational barrel right-shifter returning the integer part plus the
// guard, round and sticky bits of everything shifted out.
module vfpu_rshift #(
  parameter int W  = 24,
  parameter int AW = 8
) (
  input  logic [W-1:0]  data,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  q,
  output logic          guard,
  output logic          round,
  output logic          sticky
);
  localparam int XW = 2 * W + 2;

  logic [AW-1:0] amt_c;
  logic [XW-1:0] ext;
  logic [XW-1:0] shifted;

  // Past W+2 every bit already lands below the round position, so clamping
  // keeps the whole operand inside the sticky window.
  assign amt_c   = (amt > AW'(W + 2)) ? AW'(W + 2) : amt;
  assign ext     = {data, {(W + 2){1'b0}}};
  assign shifted = ext >> amt_c;

  assign q      = shifted[XW-1:W+2];
  assign guard  = shifted[W+1];
  assign round  = shifted[W];
  assign sticky = |shifted[W-1:0];
endmodule

// File: rtl/vfpu_f2i.sv
// FP32 to INT_WIDTH integer, 2 stages, 1/cycle; stalls hold both stages in place.
// VFPU_F2I_RNE_EN selects round-to-nearest-even, otherwise round toward zero.
module vfpu_f2i
  import hwpe_ctrl_vfpu_package::*;
#(
  parameter int INT_WIDTH = 32
) (
  input logic        clk_i,
  input logic        rst_ni,
  vfpu_f2i_if.slave  bus
);
  localparam logic [33:0] LIM_S = 34'(1) << (INT_WIDTH - 1);
  localparam logic [33:0] LIM_U = (34'(1) << INT_WIDTH) - 34'd1;
  localparam logic [INT_WIDTH-1:0] MAX_POS = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] MIN_NEG = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic [INT_WIDTH-1:0] ONES    = {INT_WIDTH{1'b1}};

  logic [FP32_EXP_W-1:0] in_exp;
  logic [FP32_MAN_W-1:0] in_man;
  fp_class_t             in_cls;

  logic                  s1_valid, s1_sign, s1_signed;
  fp_class_t             s1_cls;
  logic signed [9:0]     s1_shift;
  logic [FP32_MAN_W:0]   s1_mant;

  logic                  out_valid;
  logic [INT_WIDTH-1:0]  out_data;
  vfpu_f2i_flags_t       out_flags;
  logic                  s2_ready, in_ready;

  assign s2_ready = ~out_valid | bus.out_ready_i;
  assign in_ready = ~s1_valid | s2_ready;

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_data;
  assign bus.out_flags_o = out_flags;

  assign in_exp = bus.in_data_i[FP32_MAN_W +: FP32_EXP_W];
  assign in_man = bus.in_data_i[FP32_MAN_W-1:0];

  always_comb begin
    in_cls = NORMAL;
    if (in_exp == '0)      in_cls = (in_man == '0) ? ZERO : SUBNORM;
    else if (&in_exp)      in_cls = (in_man == '0) ? INF : NAN;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_signed <= 1'b0;
      s1_cls    <= ZERO;
      s1_shift  <= '0;
      s1_mant   <= '0;
    end else begin
      if (in_ready) s1_valid <= bus.in_valid_i;
      if (bus.in_valid_i && in_ready) begin
        s1_sign   <= bus.in_data_i[31];
        s1_signed <= bus.in_signed_i;
        s1_cls    <= in_cls;
        s1_shift  <= $signed({2'b00, in_exp}) - 10'(FP32_BIAS);
        s1_mant   <= {in_exp != '0, in_man};
      end
    end
  end

  // Stage 2: integer part is mant * 2^(shift - 23); left shifts are exact.
  logic                 big, left, inc;
  logic [7:0]           ramt;
  logic [3:0]           lamt;
  logic [FP32_MAN_W:0]  rq;
  logic                 guard, round, sticky;
  logic [33:0]          mag;
  logic [INT_WIDTH-1:0] mag_w;

  assign big  = s1_shift > $signed(10'(INT_WIDTH));
  assign left = s1_shift > $signed(10'(FP32_MAN_W));
  assign ramt = left ? 8'd0 : 8'($signed(10'(FP32_MAN_W)) - s1_shift);
  assign lamt = 4'(s1_shift - $signed(10'(FP32_MAN_W)));

  vfpu_rshift #(.W(FP32_MAN_W + 1), .AW(8)) u_rshift (
    .data   (s1_mant),
    .amt    (ramt),
    .q      (rq),
    .guard  (guard),
    .round  (round),
    .sticky (sticky)
  );

`ifdef VFPU_F2I_RNE_EN
  assign inc = guard & (round | sticky | rq[0]);
`else
  assign inc = 1'b0;
`endif

  assign mag   = left ? (34'(s1_mant) << lamt) : (34'(rq) + 34'(inc));
  assign mag_w = mag[INT_WIDTH-1:0];

  logic                 ovf;
  logic [INT_WIDTH-1:0] sat, res_d;
  vfpu_f2i_flags_t      flg_d;

  always_comb begin
    res_d = '0;
    flg_d = '0;
    sat   = s1_signed ? (s1_sign ? MIN_NEG : MAX_POS) : (s1_sign ? '0 : ONES);
    // Range is judged on the rounded magnitude so a round-up past the limit saturates.
    if (s1_signed) ovf = big | (mag > (s1_sign ? LIM_S : LIM_S - 34'd1));
    else           ovf = s1_sign ? (big | (mag != '0)) : (big | (mag > LIM_U));
    unique case (s1_cls)
      ZERO:    ;
      SUBNORM: flg_d.inexact = 1'b1;
      NAN: begin
        res_d         = s1_signed ? MAX_POS : ONES;
        flg_d.invalid = 1'b1;
      end
      INF: begin
        res_d         = sat;
        flg_d.invalid = 1'b1;
      end
      default: begin
        if (ovf) begin
          res_d         = sat;
          flg_d.invalid = 1'b1;
        end else begin
          res_d         = s1_sign ? -mag_w : mag_w;
          flg_d.inexact = ~left & (guard | round | sticky);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= res_d;
        out_flags <= flg_d;
      end
    end
  end
endmodule
